// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - command, ALU, shifter and FSM types shared by datapath_seq
package datapath_pkg;

  typedef enum logic [1:0] {
    K_MOV_IMM = 2'b00,
    K_MOV     = 2'b01,
    K_ALU     = 2'b10,
    K_CMP     = 2'b11
  } cmd_kind_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_NOT = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL1 = 2'b01,
    SH_LSR1 = 2'b10,
    SH_ASR1 = 2'b11
  } shift_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_EXEC,
    S_WB
  } state_e;

  localparam int ST_N = 2;
  localparam int ST_V = 1;
  localparam int ST_Z = 0;

endpackage

// File: rtl/datapath_regfile.sv
// rtl/datapath_regfile.sv - general register file, one write port, two async read ports
// Indices at or above NREGS read as zero and are never written.
module datapath_regfile #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(NREGS)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(NREGS)-1:0] raddr0,
  output logic [WIDTH-1:0]         rdata0,
  input  logic [$clog2(NREGS)-1:0] raddr1,
  output logic [WIDTH-1:0]         rdata1
);

  logic [WIDTH-1:0] mem [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (int'(waddr) < NREGS)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata0 = (int'(raddr0) < NREGS) ? mem[raddr0] : '0;
  assign rdata1 = (int'(raddr1) < NREGS) ? mem[raddr1] : '0;

endmodule

// File: rtl/datapath_seq.sv
// rtl/datapath_seq.sv - register/ALU datapath driven by a single-command micro-sequencer
// Optional debug read port (dbg_addr/dbg_data) enabled by DATAPATH_SEQ_DBG_EN.
module datapath_seq
  import datapath_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int IMM_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_kind,
  input  logic [1:0]               cmd_aluop,
  input  logic [1:0]               cmd_shift,
  input  logic                     cmd_use_imm,
  input  logic [$clog2(NREGS)-1:0] cmd_rd,
  input  logic [$clog2(NREGS)-1:0] cmd_rn,
  input  logic [$clog2(NREGS)-1:0] cmd_rm,
  input  logic [IMM_W-1:0]         cmd_imm,
`ifdef DATAPATH_SEQ_DBG_EN
  input  logic [$clog2(NREGS)-1:0] dbg_addr,
  output logic [WIDTH-1:0]         dbg_data,
`endif
  output logic                     done,
  output logic [WIDTH-1:0]         datapath_out,
  output logic [2:0]               status_out
);

  localparam int RW = $clog2(NREGS);

  state_e            state, state_n;
  cmd_kind_e         kind_q;
  alu_op_e           aluop_q, op_eff;
  shift_e            shift_q;
  logic              use_imm_q, imm_sel, rf_we, alu_v;
  logic [RW-1:0]     rd_q, rn_q, rm_q, raddr0, raddr1;
  logic [IMM_W-1:0]  imm_q;
  logic [WIDTH-1:0]  a_q, b_q, c_q, b_src, rdata0, rdata1;
  logic [WIDTH-1:0]  imm_ext, b_shift, ain, bin, alu_res, rf_wdata;
  logic [2:0]        st_q, st_next;

  assign imm_ext = WIDTH'(signed'(imm_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    cmd_ready = 1'b0;
    done      = 1'b0;
    unique case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          unique case (cmd_kind_e'(cmd_kind))
            K_MOV_IMM: state_n = S_WB;
            K_MOV:     state_n = S_LOAD_B;
            default:   state_n = S_LOAD_A;
          endcase
        end
      end
      S_LOAD_A: state_n = use_imm_q ? S_EXEC : S_LOAD_B;
      S_LOAD_B: state_n = S_EXEC;
      S_EXEC:   state_n = S_WB;
      S_WB: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default:  state_n = S_IDLE;
    endcase
  end

  // With the debug port, read port 1 belongs to dbg_addr, so operands share port 0.
`ifdef DATAPATH_SEQ_DBG_EN
  assign raddr0   = (state == S_LOAD_B) ? rm_q : rn_q;
  assign raddr1   = dbg_addr;
  assign b_src    = rdata0;
  assign dbg_data = rdata1;
`else
  assign raddr0   = rn_q;
  assign raddr1   = rm_q;
  assign b_src    = rdata1;
`endif

  assign rf_we    = (state == S_WB) && (kind_q != K_CMP);
  assign rf_wdata = (kind_q == K_MOV_IMM) ? imm_ext : c_q;

  datapath_regfile #(.WIDTH(WIDTH), .NREGS(NREGS)) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (rf_we),
    .waddr  (rd_q),
    .wdata  (rf_wdata),
    .raddr0 (raddr0),
    .rdata0 (rdata0),
    .raddr1 (raddr1),
    .rdata1 (rdata1)
  );

  always_comb begin
    b_shift = b_q;
    unique case (shift_q)
      SH_LSL1: b_shift = {b_q[WIDTH-2:0], 1'b0};
      SH_LSR1: b_shift = {1'b0, b_q[WIDTH-1:1]};
      SH_ASR1: b_shift = {b_q[WIDTH-1], b_q[WIDTH-1:1]};
      default: b_shift = b_q;
    endcase
  end

  // Immediate operand only applies to ALU/CMP; MOV always passes the shifted B register.
  assign imm_sel = use_imm_q && kind_q[1];
  assign ain     = (kind_q == K_MOV) ? '0 : a_q;
  assign bin     = imm_sel ? imm_ext : b_shift;
  assign op_eff  = (kind_q == K_MOV) ? OP_ADD : aluop_q;

  always_comb begin
    alu_res = ain + bin;
    alu_v   = 1'b0;
    unique case (op_eff)
      OP_ADD: begin
        alu_res = ain + bin;
        alu_v   = (ain[WIDTH-1] == bin[WIDTH-1]) && (alu_res[WIDTH-1] != ain[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = ain - bin;
        alu_v   = (ain[WIDTH-1] != bin[WIDTH-1]) && (alu_res[WIDTH-1] != ain[WIDTH-1]);
      end
      OP_AND:  alu_res = ain & bin;
      default: alu_res = ~bin;
    endcase
    st_next       = '0;
    st_next[ST_N] = alu_res[WIDTH-1];
    st_next[ST_V] = alu_v;
    st_next[ST_Z] = (alu_res == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kind_q    <= K_MOV_IMM;
      aluop_q   <= OP_ADD;
      shift_q   <= SH_NONE;
      use_imm_q <= 1'b0;
      rd_q      <= '0;
      rn_q      <= '0;
      rm_q      <= '0;
      imm_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      st_q      <= '0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        kind_q    <= cmd_kind_e'(cmd_kind);
        aluop_q   <= alu_op_e'(cmd_aluop);
        shift_q   <= shift_e'(cmd_shift);
        use_imm_q <= cmd_use_imm;
        rd_q      <= cmd_rd;
        rn_q      <= cmd_rn;
        rm_q      <= cmd_rm;
        imm_q     <= cmd_imm;
      end
      if (state == S_LOAD_A) a_q <= rdata0;
      if (state == S_LOAD_B) b_q <= b_src;
      if (state == S_EXEC) begin
        c_q <= alu_res;
        if (kind_q == K_ALU || kind_q == K_CMP) st_q <= st_next;
      end
    end
  end

  assign datapath_out = c_q;
  assign status_out   = st_q;

endmodule

// File: tb/tb_datapath_seq.sv
// tb/tb_datapath_seq.sv - self-checking bench for datapath_seq: vector table, corner sequences, random vs model
module tb_datapath_seq;

  localparam int WIDTH = 16;
  localparam int NREGS = 8;
  localparam int IMM_W = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_kind = '0, cmd_aluop = '0, cmd_shift = '0;
  logic        cmd_use_imm = 1'b0;
  logic [2:0]  cmd_rd = '0, cmd_rn = '0, cmd_rm = '0;
  logic [7:0]  cmd_imm = '0;
  logic        cmd_ready, done;
  logic [15:0] datapath_out;
  logic [2:0]  status_out;
`ifdef DATAPATH_SEQ_DBG_EN
  logic [2:0]  dbg_addr = '0;
  logic [15:0] dbg_data;
`endif

  datapath_seq #(.WIDTH(WIDTH), .NREGS(NREGS), .IMM_W(IMM_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_kind     (cmd_kind),
    .cmd_aluop    (cmd_aluop),
    .cmd_shift    (cmd_shift),
    .cmd_use_imm  (cmd_use_imm),
    .cmd_rd       (cmd_rd),
    .cmd_rn       (cmd_rn),
    .cmd_rm       (cmd_rm),
    .cmd_imm      (cmd_imm),
`ifdef DATAPATH_SEQ_DBG_EN
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data),
`endif
    .done         (done),
    .datapath_out (datapath_out),
    .status_out   (status_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] kind, op, sh;
    logic       ui;
    logic [2:0] rd, rn, rm;
    logic [7:0] imm;
  } cmd_t;

  typedef struct {
    cmd_t        c;
    int          lat;
    logic [15:0] out;
    logic [2:0]  st;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  vec_t tbl[$];
  int   mdl_r[8];
  int   mdl_c = 0;
  int   mdl_st = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic cmd_t mk(input int kind, input int op, input int sh, input int ui,
                              input int rd, input int rn, input int rm, input int imm);
    cmd_t c;
    c.kind = kind[1:0]; c.op = op[1:0]; c.sh = sh[1:0]; c.ui = ui[0];
    c.rd = rd[2:0]; c.rn = rn[2:0]; c.rm = rm[2:0]; c.imm = imm[7:0];
    return c;
  endfunction

  task automatic add_vec(input cmd_t c, input int lat, input int out, input int st);
    vec_t v;
    v.c = c; v.lat = lat; v.out = out[15:0]; v.st = st[2:0];
    tbl.push_back(v);
  endtask

  function automatic int sext(input logic [7:0] i);
    return i[7] ? int'(i) + 'hFF00 : int'(i);
  endfunction

  function automatic int shifted(input int x, input logic [1:0] sh);
    case (sh)
      2'd1:    return (x * 2) & 'hFFFF;
      2'd2:    return x / 2;
      2'd3:    return (x / 2) | (x & 'h8000);
      default: return x;
    endcase
  endfunction

  function automatic int to_signed(input int x);
    return (x >= 32768) ? x - 65536 : x;
  endfunction

  // Reference: executes one command on plain integers; returns the expected latency.
  task automatic mdl_apply(input cmd_t c, output int lat);
    int a, b, r, sr, v;
    case (c.kind)
      2'd0: begin
        mdl_r[c.rd] = sext(c.imm);
        lat = 1;
      end
      2'd1: begin
        r = shifted(mdl_r[c.rm], c.sh);
        mdl_c = r;
        mdl_r[c.rd] = r;
        lat = 3;
      end
      default: begin
        a   = mdl_r[c.rn];
        b   = c.ui ? sext(c.imm) : shifted(mdl_r[c.rm], c.sh);
        lat = c.ui ? 3 : 4;
        v   = 0;
        case (c.op)
          2'd0: begin sr = to_signed(a) + to_signed(b); v = (sr > 32767 || sr < -32768) ? 1 : 0; end
          2'd1: begin sr = to_signed(a) - to_signed(b); v = (sr > 32767 || sr < -32768) ? 1 : 0; end
          2'd2: sr = a & b;
          default: sr = ~b;
        endcase
        r = sr & 'hFFFF;
        mdl_c  = r;
        mdl_st = ((r >= 32768) ? 4 : 0) + (v * 2) + ((r == 0) ? 1 : 0);
        if (c.kind == 2'd2) mdl_r[c.rd] = r;
      end
    endcase
  endtask

  task automatic drive_cmd(input cmd_t c);
    cmd_kind = c.kind; cmd_aluop = c.op; cmd_shift = c.sh; cmd_use_imm = c.ui;
    cmd_rd = c.rd; cmd_rn = c.rn; cmd_rm = c.rm; cmd_imm = c.imm;
  endtask

  task automatic run_cmd(input cmd_t c, output int lat);
    @(negedge clk);
    check("idle_ready", {31'd0, cmd_ready}, 1);
    check("idle_done", {31'd0, done}, 0);
    drive_cmd(c);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!done && lat < 12) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_model_checked(input cmd_t c, input string tag);
    int lat, elat;
    run_cmd(c, lat);
    mdl_apply(c, elat);
    check({tag, "_lat"}, lat, elat);
    check({tag, "_out"}, {16'd0, datapath_out}, mdl_c);
    check({tag, "_st"}, {29'd0, status_out}, mdl_st);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    cmd_t c;
    int   lat, elat, seen;
    int   peek_exp[8];

    for (int i = 0; i < 8; i++) mdl_r[i] = 0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, cmd_ready}, 1);
    check("rst_done", {31'd0, done}, 0);
    check("rst_out", {16'd0, datapath_out}, 0);
    check("rst_st", {29'd0, status_out}, 0);
    rst_n = 1'b1;

    // kind op sh ui rd rn rm imm | latency, datapath_out, status
    add_vec(mk(0, 0, 0, 0, 3, 0, 0, 42),     1, 'h0000, 3'b000);
    add_vec(mk(0, 0, 0, 0, 5, 0, 0, 13),     1, 'h0000, 3'b000);
    add_vec(mk(2, 0, 0, 0, 2, 3, 5, 0),      4, 'h0037, 3'b000);
    add_vec(mk(0, 0, 0, 0, 1, 0, 0, 'h1A),   1, 'h0037, 3'b000);
    for (int i = 1; i <= 8; i++) add_vec(mk(1, 0, 1, 0, 1, 0, 1, 0), 3, ('h1A << i) & 'hFFFF, 3'b000);
    add_vec(mk(2, 0, 0, 1, 1, 1, 0, 'hA2),   3, 'h19A2, 3'b000);
    add_vec(mk(1, 0, 0, 0, 4, 0, 1, 0),      3, 'h19A2, 3'b000);
    add_vec(mk(3, 1, 0, 0, 5, 1, 4, 0),      4, 'h0000, 3'b001);
    add_vec(mk(0, 0, 0, 0, 1, 0, 0, 'h80),   1, 'h0000, 3'b001);
    add_vec(mk(1, 0, 2, 0, 1, 0, 1, 0),      3, 'h7FC0, 3'b001);
    add_vec(mk(2, 0, 0, 1, 1, 1, 0, 'h3F),   3, 'h7FFF, 3'b000);
    add_vec(mk(0, 0, 0, 0, 4, 0, 0, 'hFF),   1, 'h7FFF, 3'b000);
    add_vec(mk(3, 1, 0, 0, 3, 1, 4, 0),      4, 'h8000, 3'b110);
    add_vec(mk(2, 0, 0, 1, 4, 1, 0, 'h01),   3, 'h8000, 3'b110);
    add_vec(mk(1, 0, 3, 0, 7, 0, 4, 0),      3, 'hC000, 3'b110);
    add_vec(mk(1, 0, 2, 0, 7, 0, 4, 0),      3, 'h4000, 3'b110);
    add_vec(mk(2, 0, 0, 1, 6, 3, 0, 'hFE),   3, 'h0028, 3'b000);
    add_vec(mk(0, 0, 0, 0, 0, 0, 0, 'h80),   1, 'h0028, 3'b000);
    add_vec(mk(2, 2, 0, 0, 2, 1, 4, 0),      4, 'h0000, 3'b001);
    add_vec(mk(2, 3, 1, 0, 2, 0, 7, 0),      4, 'h7FFF, 3'b000);

    foreach (tbl[i]) begin
      run_cmd(tbl[i].c, lat);
      mdl_apply(tbl[i].c, elat);
      check($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
      check($sformatf("tbl%0d_out", i), {16'd0, datapath_out}, {16'd0, tbl[i].out});
      check($sformatf("tbl%0d_st", i), {29'd0, status_out}, {29'd0, tbl[i].st});
    end

    // MOV rd=r rm=r copies a register into C without changing it or the status.
    peek_exp = '{'hFF80, 'h7FFF, 'h7FFF, 'h002A, 'h8000, 'h000D, 'h0028, 'h4000};
    for (int r = 0; r < 8; r++) begin
      c = mk(1, 0, 0, 0, r, 0, r, 0);
      run_cmd(c, lat);
      mdl_apply(c, elat);
      check($sformatf("peek_r%0d", r), {16'd0, datapath_out}, peek_exp[r]);
      check($sformatf("peek_st%0d", r), {29'd0, status_out}, 0);
    end

    // Reset asserted while an ALU command sits in EXEC.
    @(negedge clk);
    drive_cmd(mk(2, 0, 0, 0, 2, 1, 4, 0));
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", {31'd0, cmd_ready}, 1);
    check("midrst_done", {31'd0, done}, 0);
    check("midrst_out", {16'd0, datapath_out}, 0);
    check("midrst_st", {29'd0, status_out}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check("midrst_no_done", seen, 0);
    check("midrst_ready_after", {31'd0, cmd_ready}, 1);
    for (int i = 0; i < 8; i++) mdl_r[i] = 0;
    mdl_c = 0;
    mdl_st = 0;
    for (int r = 0; r < 8; r++) run_model_checked(mk(1, 0, 0, 0, r, 0, r, 0), $sformatf("zero_r%0d", r));

    // cmd_valid held with new fields while busy must not start another command.
    run_model_checked(mk(0, 0, 0, 0, 1, 0, 0, 5), "busy_pre");
    @(negedge clk);
    drive_cmd(mk(2, 0, 0, 0, 2, 1, 1, 0));
    cmd_valid = 1'b1;
    @(negedge clk);
    drive_cmd(mk(0, 0, 0, 0, 6, 0, 0, 'h77));
    lat = 1;
    while (!done && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    cmd_valid = 1'b0;
    mdl_apply(mk(2, 0, 0, 0, 2, 1, 1, 0), elat);
    check("busy_lat", lat, 4);
    check("busy_out", {16'd0, datapath_out}, 'h000A);
    run_model_checked(mk(1, 0, 0, 0, 6, 0, 6, 0), "busy_r6");
    run_model_checked(mk(1, 0, 0, 0, 2, 0, 2, 0), "busy_r2");

    for (int n = 0; n < 40; n++) begin
      c = mk($urandom_range(3), $urandom_range(3), $urandom_range(3), $urandom_range(1),
             $urandom_range(7), $urandom_range(7), $urandom_range(7), $urandom_range(255));
      if (c.kind == 2'd1) c.ui = 1'b0;
      run_model_checked(c, $sformatf("rnd%0d", n));
    end
    for (int r = 0; r < 8; r++) run_model_checked(mk(1, 0, 0, 0, r, 0, r, 0), $sformatf("final_r%0d", r));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/datapath_seq.md
Name: datapath_seq

Overview:
- Parametrised successor to the lab datapath: register file, A/B/C pipeline registers, B-operand shifter, 4-op ALU, status register.
- Adds a built-in micro-sequencer. A single command is accepted over a valid/ready handshake and executed over 2–5 cycles, with no external loada/loadb/loadc/write strobing.
- Adds N and V status flags and width/depth generalisation.
- Sits between the future instruction decoder and the register/ALU resources.

Parameters:
- WIDTH, 16, datapath word width (>=4)
- NREGS, 8, number of general registers (2..32)
- IMM_W, 8, immediate field width (<= WIDTH), sign-extended to WIDTH

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE; command accepted on cmd_valid&&cmd_ready at a clk edge
- cmd_kind  in  2  00 MOV_IMM, 01 MOV, 10 ALU, 11 CMP
- cmd_aluop  in  2  00 add, 01 sub (A-B), 10 and, 11 not B
- cmd_shift  in  2  00 none, 01 lsl1, 10 lsr1, 11 asr1 (applied to B register only)
- cmd_use_imm  in  1  ALU/CMP: Bin = sext(imm), shifter bypassed, no LOAD_B
- cmd_rd, cmd_rn, cmd_rm  in  $clog2(NREGS) each  register indices
- cmd_imm  in  IMM_W  immediate
- done  out  1  one-cycle pulse in WB state
- datapath_out  out  WIDTH  C register
- status_out  out  3  {N,V,Z}

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All registers R0..R(NREGS-1), A, B, C and status cleared to 0.
  - done=0, cmd_ready=1 once rst_n is released.
- Command capture: all cmd_* fields are latched on acceptance. Inputs are don't-care afterwards.
- FSM states: IDLE, LOAD_A, LOAD_B, EXEC, WB.
  - IDLE, on accept:
    - MOV_IMM -> WB
    - MOV -> LOAD_B
    - ALU/CMP -> LOAD_A
  - LOAD_A: A<=R[rn]. Next state is EXEC if use_imm, else LOAD_B.
  - LOAD_B: B<=R[rm] -> EXEC.
  - EXEC:
    - C<=ALU(Ain,Bin).
    - Ain=0 for MOV (asel), else A.
    - Bin=sext(imm) if use_imm, else shift(B).
    - ALU forced to add for MOV.
    - -> WB.
  - WB:
    - done=1.
    - MOV_IMM: R[rd]<=sext(imm), C unchanged.
    - MOV/ALU: R[rd]<=C.
    - CMP: no register write.
    - -> IDLE.
- Latency, accept edge to done cycle:
  - MOV_IMM: 1 cycle
  - MOV: 3 cycles
  - ALU with use_imm: 3 cycles
  - ALU/CMP register form: 4 cycles
- Back-to-back: a new command can be accepted in the cycle after WB. A write in WB is visible to a LOAD_A/LOAD_B of the next command, so no hazard exists.
- Status is updated only in EXEC of ALU and CMP. MOV and MOV_IMM leave it unchanged.
  - Z = (result==0).
  - N = result[WIDTH-1].
  - V = signed overflow for add/sub; 0 for and/not.
- Arithmetic: modulo 2^WIDTH, carry discarded.
- Shifter:
  - lsr1 inserts 0.
  - asr1 replicates bit WIDTH-1.
  - lsl1 inserts 0 at bit 0.
- Index out of range (NREGS not a power of 2): reads return 0, writes ignored.
- rd==rn==rm is legal. Reads occur in earlier states than the WB write.
- Reset mid-command: the command is abandoned immediately, no write, done stays 0, and all state returns to reset values.
- cmd_valid held while not ready: ignored, no queueing.

Optional Feature:
- Macro DATAPATH_SEQ_DBG_EN.
- Defined:
  - Adds ports dbg_addr (in, $clog2(NREGS)) and dbg_data (out, WIDTH).
  - dbg_data = R[dbg_addr], combinational.
  - Reads the value after the current cycle's committed state, never the in-flight write.
- Undefined: ports absent; no added logic.

Decomposition:
- Package datapath_pkg:
  - cmd_kind_e, alu_op_e, shift_e, state_e enums.
  - Status bit index constants ST_N=2, ST_V=1, ST_Z=0.
- Sub-module datapath_regfile (WIDTH, NREGS):
  - one write port, two async read ports, async active-low clear.
- Shifter and ALU stay as combinational logic inside datapath_seq.

Test Plan:
- MOV_IMM rd=3 imm=42 then MOV_IMM rd=5 imm=13 -> each done 1 cycle after accept; R3=0x002A, R5=0x000D; status stays 000.
- ALU add rd=2 rn=3 rm=5 shift=00 -> done 4 cycles after accept; R2=0x0037, datapath_out=0x0037, status 000.
- CMP sub with R1=0x19A2, R4=0x19A2 -> Z=1, N=0, V=0, no register changes. Repeat with R1=0x7FFF, R4=0xFFFF (sub) -> result 0x8000, N=1, V=1, Z=0.
- MOV rd=7 rm=4 (R4=0x8000) with shift=11 -> R7=0xC000; shift=10 -> R7=0x4000; status unchanged.
- ALU use_imm aluop=00 rn=3 (0x002A) imm=0xFE -> done 3 cycles after accept; R[rd]=0x0028. MOV_IMM imm=0x80 -> 0xFF80.
- rst_n low during EXEC of an ALU command -> cmd_ready=1 after release, no done pulse, all registers/datapath_out/status 0. cmd_valid asserted during busy states -> ignored.
